// File: rtl/param_shift_reg.sv
// Parameterised shift register with per-cycle operations and counted bursts.
// Stage i occupies pout[i*WIDTH +: WIDTH]; "up" moves data toward stage DEPTH-1.
module param_shift_reg #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [2:0]                       mode,
    input  logic [WIDTH-1:0]                 sin,
    input  logic [WIDTH*DEPTH-1:0]           pin,
    input  logic                             start,
    input  logic [CNT_W-1:0]                 count,
    output logic [WIDTH*DEPTH-1:0]           pout,
    output logic [WIDTH-1:0]                 sout_up,
    output logic [WIDTH-1:0]                 sout_dn,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(DEPTH+1)-1:0]       fill
);

    localparam int unsigned DATA_W = WIDTH * DEPTH;
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    localparam logic [2:0] MODE_SHUP  = 3'b001;
    localparam logic [2:0] MODE_SHDN  = 3'b010;
    localparam logic [2:0] MODE_ROTUP = 3'b011;
    localparam logic [2:0] MODE_ROTDN = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLR   = 3'b110;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [2:0]          bmode_q, bmode_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                op_en;
    logic [2:0]          op_mode;
    logic                burst_mode;

    // Only the four movement modes may run as a counted burst
    assign burst_mode = (mode == MODE_SHUP) || (mode == MODE_SHDN) ||
                        (mode == MODE_ROTUP) || (mode == MODE_ROTDN);

    // Next-state, burst bookkeeping and datapath operation
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        fill_d  = fill_q;
        rem_d   = rem_q;
        bmode_d = bmode_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        op_en   = 1'b0;
        op_mode = mode;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Accept edge latches the burst and performs no operation
                    if (burst_mode) begin
                        bmode_d = mode;
                        rem_d   = count;
                        if (count != CNT_W'(0)) begin
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end else if (en) begin
                    op_en   = 1'b1;
                    op_mode = mode;
                end
            end
            RUN: begin
                if (en) begin
                    op_en   = 1'b1;
                    op_mode = bmode_q;
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (op_en) begin
            case (op_mode)
                MODE_SHUP: begin
                    data_d = {data_q[DATA_W-WIDTH-1:0], sin};
                    if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);
                end
                MODE_SHDN: begin
                    data_d = {sin, data_q[DATA_W-1:WIDTH]};
                    if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);
                end
                MODE_ROTUP: data_d = {data_q[DATA_W-WIDTH-1:0], data_q[DATA_W-1 -: WIDTH]};
                MODE_ROTDN: data_d = {data_q[WIDTH-1:0], data_q[DATA_W-1:WIDTH]};
                MODE_LOAD: begin
                    data_d = pin;
                    fill_d = FILL_W'(DEPTH);
                end
                MODE_CLR: begin
                    data_d = '0;
                    fill_d = '0;
                end
                default: ;
            endcase
        end
    end

    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            fill_q  <= '0;
            rem_q   <= '0;
            bmode_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            rem_q   <= rem_d;
            bmode_q <= bmode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pout    = data_q;
    assign fill    = fill_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sout_up = data_q[DATA_W-1 -: WIDTH];
    assign sout_dn = data_q[WIDTH-1:0];

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg (WIDTH=1, DEPTH=4).
module tb_param_shift_reg;

    logic       clk = 1'b0;
    logic       rst, en, start;
    logic [2:0] mode;
    logic [0:0] sin;
    logic [3:0] pin;
    logic [7:0] count;
    logic [3:0] pout;
    logic [0:0] sout_up, sout_dn;
    logic       busy, done;
    logic [2:0] fill;

    int total = 0;
    int bad   = 0;

    // Reference model: a list of stage values plus burst bookkeeping
    bit m[4];
    int m_fill;
    bit m_busy, m_done;
    int m_rem;
    int m_mode;

    param_shift_reg #(.WIDTH(1), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pin(pin),
        .start(start), .count(count), .pout(pout), .sout_up(sout_up),
        .sout_dn(sout_dn), .busy(busy), .done(done), .fill(fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] m_pack();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = m[i];
        return r;
    endfunction

    task automatic m_apply(input int op, input bit s);
        bit old[4];
        old = m;
        case (op)
            1: begin
                m[0] = s;
                for (int i = 1; i < 4; i++) m[i] = old[i-1];
                if (m_fill < 4) m_fill++;
            end
            2: begin
                m[3] = s;
                for (int i = 0; i < 3; i++) m[i] = old[i+1];
                if (m_fill < 4) m_fill++;
            end
            3: for (int i = 0; i < 4; i++) m[i] = old[(i + 3) % 4];
            4: for (int i = 0; i < 4; i++) m[i] = old[(i + 1) % 4];
            5: begin
                for (int i = 0; i < 4; i++) m[i] = pin[i];
                m_fill = 4;
            end
            6: begin
                for (int i = 0; i < 4; i++) m[i] = 1'b0;
                m_fill = 0;
            end
            default: ;
        endcase
    endtask

    task automatic m_step();
        m_done = 1'b0;
        if (rst) begin
            for (int i = 0; i < 4; i++) m[i] = 1'b0;
            m_fill = 0; m_busy = 1'b0; m_rem = 0;
        end else if (!m_busy) begin
            if (start) begin
                if (mode >= 3'd1 && mode <= 3'd4) begin
                    m_mode = int'(mode);
                    m_rem  = int'(count);
                    if (m_rem == 0) m_done = 1'b1;
                    else            m_busy = 1'b1;
                end
            end else if (en) begin
                m_apply(int'(mode), sin[0]);
            end
        end else if (en) begin
            m_apply(m_mode, sin[0]);
            m_rem--;
            if (m_rem == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end
    endtask

    // One clock: advance the model with the same inputs, then compare 1 time unit later
    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
        chk("pout", 32'(pout), 32'(m_pack()));
        chk("fill", 32'(fill), 32'(m_fill));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("sout_up", 32'(sout_up), 32'(m[3]));
        chk("sout_dn", 32'(sout_dn), 32'(m[0]));
    endtask

    task automatic drive(input bit r, input bit e, input bit [2:0] md, input bit s,
                         input bit [3:0] p, input bit st, input bit [7:0] c);
        rst = r; en = e; mode = md; sin = s; pin = p; start = st; count = c;
    endtask

    initial begin
        logic [3:0] serial;
        int done_cnt;
        m_fill = 0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_mode = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        cyc();

        // Random activity, then a two-cycle reset
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'($urandom), 3'($urandom), 1'($urandom), 4'($urandom),
                  ($urandom % 4) == 0, 8'($urandom % 4));
            cyc();
        end
        drive(1, 1, 3'd5, 1, 4'hF, 1, 8'd3);
        cyc(); cyc();
        chk("rst_pout", 32'(pout), 32'h0);
        chk("rst_fill", 32'(fill), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // Serial fill via shift-up
        serial = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 3'd1, serial[i], 0, 0, 0);
            cyc();
        end
        chk("serial_pout", 32'(pout), 32'b1110);
        chk("serial_fill", 32'(fill), 32'd4);
        chk("serial_sout_up", 32'(sout_up), 32'd1);
        chk("serial_sout_dn", 32'(sout_dn), 32'd0);

        // Burst rotate-up of 3
        drive(0, 1, 3'd5, 0, 4'b1001, 0, 0);
        cyc();
        drive(0, 1, 3'd3, 0, 0, 1, 8'd3);
        cyc();
        chk("burst_accept_busy", 32'(busy), 32'd1);
        chk("burst_accept_pout", 32'(pout), 32'b1001);
        drive(0, 1, 3'd6, 1, 4'hF, 1, 8'd9);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            chk("burst_busy", 32'(busy), 32'd1);
            cyc();
            if (done) done_cnt++;
        end
        chk("burst_pout", 32'(pout), 32'b1100);
        chk("burst_fill", 32'(fill), 32'd4);
        chk("burst_end_busy", 32'(busy), 32'd0);
        drive(0, 0, 3'd0, 0, 0, 0, 0);
        cyc();
        if (done) done_cnt++;
        chk("burst_done_pulses", 32'(done_cnt), 32'd1);

        // Same burst with a two-cycle stall after the first operation
        drive(0, 1, 3'd5, 0, 4'b1001, 0, 0);
        cyc();
        drive(0, 1, 3'd3, 0, 0, 1, 8'd3);
        cyc();
        drive(0, 1, 3'd0, 0, 0, 0, 0);
        cyc();
        chk("stall_op1_pout", 32'(pout), 32'b0011);
        drive(0, 0, 3'd0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_pout", 32'(pout), 32'b0011);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_done", 32'(done), 32'd0);
        end
        drive(0, 1, 3'd0, 0, 0, 0, 0);
        cyc();
        chk("stall_op2_done", 32'(done), 32'd0);
        cyc();
        chk("stall_final_done", 32'(done), 32'd1);
        chk("stall_final_pout", 32'(pout), 32'b1100);

        // Zero-count start and illegal-mode start
        drive(0, 1, 3'd1, 1, 0, 1, 8'd0);
        cyc();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_pout", 32'(pout), 32'b1100);
        drive(0, 1, 3'd5, 0, 4'b0000, 1, 8'd2);
        cyc();
        chk("illegal_done", 32'(done), 32'd0);
        chk("illegal_pout", 32'(pout), 32'b1100);
        chk("illegal_busy", 32'(busy), 32'd0);

        // Reset on the second operation of a shift-up burst
        drive(0, 1, 3'd1, 1, 0, 1, 8'd5);
        cyc();
        drive(0, 1, 3'd0, 1, 0, 0, 0);
        cyc();
        chk("midrst_busy_before", 32'(busy), 32'd1);
        drive(1, 1, 3'd0, 1, 0, 0, 0);
        cyc();
        chk("midrst_pout", 32'(pout), 32'h0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        drive(0, 0, 3'd0, 0, 0, 0, 0);
        cyc();
        chk("midrst_after_done", 32'(done), 32'd0);

        // Long randomized run against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 60) == 0, ($urandom % 4) != 0, 3'($urandom), 1'($urandom),
                  4'($urandom), ($urandom % 6) == 0, 8'($urandom % 7));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
